// File: rtl/flop13_pkg.sv
// Shared constants for the 13-bit float format {sign, exp[3:0], mant[7:0]}
// used by int_to_flop and the downstream flop arithmetic unit.
package flop13_pkg;

    localparam int SIGN_BIT = 12;
    localparam int EXP_W    = 4;
    localparam int MANT_W   = 8;
    localparam int FLT_W    = 13;

    localparam int                EXP_BIAS = 7;
    localparam logic [EXP_W-1:0]  EXP_MAX  = 4'hF;
    localparam logic [FLT_W-1:0]  FLT_ZERO = 13'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [FLT_W-1:0] pack_flt(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] m
    );
        logic [FLT_W-1:0] w;
        w                        = '0;
        w[SIGN_BIT]              = s;
        w[SIGN_BIT-1 -: EXP_W]   = e;
        w[MANT_W-1:0]            = m;
        return w;
    endfunction

endpackage

// File: rtl/int_to_flop.sv
// Signed integer to 13-bit float converter; normalises one shift per cycle
// behind a valid/ready handshake on both the input and the result side.
module int_to_flop
    import flop13_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [12:0]      out_result,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CNT_W = $clog2(IN_W);

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FLT_W-1:0]  result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [4:0]        msb_pos;
    logic              fits;
    logic [EXP_W-1:0]  exp_val;
    logic [MANT_W-1:0] mant_val;
    logic [FLT_W-1:0]  packed_val;
    logic [IN_W-1:0]   abs_in;

    // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1).
    assign abs_in = in_data[IN_W-1] ? (~in_data + IN_W'(1)) : in_data;

    // MSB position of the original magnitude, once mag_q has been normalised.
    assign msb_pos  = 5'(IN_W - 1) - 5'(cnt_q);
    assign fits     = (msb_pos <= 5'd8);
    assign exp_val  = EXP_W'(5'(EXP_BIAS) + msb_pos);
    assign mant_val = mag_q[IN_W-2 -: MANT_W];

    always_comb begin
        packed_val = pack_flt(sign_q, EXP_MAX, {MANT_W{1'b1}});
        if (fits) begin
            packed_val = pack_flt(sign_q, exp_val, mant_val);
        end
    end

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = in_data[IN_W-1];
                    mag_d   = abs_in;
                    cnt_d   = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (mag_q == '0) begin
                    result_d = FLT_ZERO;
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end else if (mag_q[IN_W-1]) begin
                    result_d = packed_val;
                    ovf_d    = ~fits;
                    state_d  = DONE;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            cnt_q    <= '0;
            result_q <= FLT_ZERO;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_int_to_flop.sv
// Randomised self-checking bench for int_to_flop against an arithmetic
// reference model of the float format and conversion latency.
module tb_int_to_flop;

    localparam int IN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [12:0]      out_result;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    int_to_flop #(.IN_W(IN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: value = 1.m * 2^p, exp = 7 + p; saturate above 511.
    function automatic void model(input int v, output logic [12:0] r, output logic ovf,
                                  output int lat);
        int mag, p, mant;
        logic s;
        s   = (v < 0);
        mag = (v < 0) ? -v : v;
        if (mag == 0) begin
            r = 13'h000; ovf = 1'b0; lat = 1;
            return;
        end
        p = 0;
        while ((1 << (p + 1)) <= mag) p++;
        lat = IN_W - p;
        if (mag > 511) begin
            r = {s, 4'hF, 8'hFF}; ovf = 1'b1;
        end else begin
            mant = ((mag - (1 << p)) * 256) / (1 << p);
            r = {s, 4'(7 + p), 8'(mant)};
            ovf = 1'b0;
        end
    endfunction

    task automatic accept(input int v);
        int n;
        logic [31:0] vb;
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk("in_ready_wait", in_ready, 1);
        vb       = v;
        in_data  = vb[IN_W-1:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("accepted", in_ready, 0);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("retired", out_valid, 0);
    endtask

    task automatic run_conv(input int v, input int hold);
        logic [12:0] er;
        logic eo;
        int el, lat;
        logic [12:0] first;
        model(v, er, eo, el);
        accept(v);
        if (hold == 0) out_ready = 1'b1;
        wait_done(lat);
        chk("latency", lat, el);
        chk("result", out_result, er);
        chk("ovf", out_ovf, eo);
        first = out_result;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, first);
        end
        handshake();
        $display("conv in=%0d result=%03h ovf=%0d lat=%0d", v, out_result, out_ovf, lat);
    endtask

    initial begin
        int fixed_v[9] = '{1, 5, -3, 300, 0, 511, 512, -32768, 256};
        int lat;
        logic [12:0] held;

        reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 13'h000);
        chk("rst_ovf", out_ovf, 0);

        foreach (fixed_v[i]) run_conv(fixed_v[i], i % 3);

        for (int i = 0; i < 40; i++) begin
            int v;
            case ($urandom_range(0, 2))
                0: v = $signed($urandom_range(0, 40)) - 20;
                1: v = $signed($urandom_range(0, 1100)) - 550;
                default: v = $signed($urandom_range(0, 65535)) - 32768;
            endcase
            run_conv(v, $urandom_range(0, 3));
        end

        // Back-pressure with a stray in_valid pulse while DONE.
        accept(5);
        wait_done(lat);
        held = out_result;
        chk("bp_result", out_result, 13'h0940);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_data  = 16'd7;
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_stable", out_result, held);
        end
        in_data = 16'd9; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bubble_idle", in_ready, 1);
        chk("bubble_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("next_accept", in_ready, 0);
        wait_done(lat);
        chk("next_lat", lat, 13);
        chk("next_result", out_result, 13'h0A20);
        handshake();
        $display("backpressure result=%03h", out_result);

        // Reset mid-normalisation of input 1.
        accept(1);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_valid", out_valid, 0);
        chk("abort_result", out_result, 13'h000);
        chk("abort_ovf", out_ovf, 0);
        $display("abort reset in_ready=%0d out_valid=%0d", in_ready, out_valid);
        run_conv(6, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
